// File: rtl/decl_sched.sv
// Two-port statement scheduler: buffers ';'-terminated statements per requester and
// replays them round-robin into the shared declaration checker. Macro DECL_SCHED_STATS_EN builds the verdict counters.
module decl_sched #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [7:0]       req0_char,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [7:0]       req1_char,
  output logic             req1_ready,
  output logic             resp0_valid,
  output logic             resp0_ok,
  output logic             resp0_ovf,
  output logic             resp1_valid,
  output logic             resp1_ok,
  output logic             resp1_ovf,
  output logic             chk_reset,
  output logic [7:0]       chk_in,
  input  logic             chk_out,
  output logic [CNT_W-1:0] ok_cnt,
  output logic [CNT_W-1:0] bad_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);
  localparam logic [7:0] SEMI = 8'h3B;

  typedef enum logic [1:0] {IDLE, CLR, SEND, VERD} state_t;
  state_t state;

  logic [1:0]          in_valid, pend, ovf, clr;
  logic [1:0][7:0]     in_char, rd_data;
  logic [1:0][CW-1:0]  cnt;
  logic                gnt, last, pick, ok_now;
  logic [AW-1:0]       idx, rd_addr;

  assign in_valid   = {req1_valid, req0_valid};
  assign in_char    = {req1_char, req0_char};
  assign req0_ready = !pend[0];
  assign req1_ready = !pend[1];
  assign clr        = (state == VERD) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
  assign pick       = (&pend) ? !last : pend[1];
  assign ok_now     = chk_out & !ovf[gnt];
  // Read address runs one entry ahead so the registered read lines up with idx.
  assign rd_addr    = (state == SEND) ? idx + AW'(1) : '0;
  assign chk_in     = (state == SEND) ? rd_data[gnt] : 8'h00;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      logic [7:0]    mem [DEPTH];
      logic [7:0]    rd_q;
      logic [CW-1:0] cnt_q;
      logic          ovf_q, pend_q, acc, semi, wr;

      assign acc  = in_valid[gi] && !pend_q;
      assign semi = (in_char[gi] == SEMI);
      assign wr   = acc && !ovf_q && ((cnt_q < LAST) || (semi && cnt_q == LAST));

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt_q  <= '0;
          ovf_q  <= 1'b0;
          pend_q <= 1'b0;
        end else if (clr[gi]) begin
          cnt_q  <= '0;
          ovf_q  <= 1'b0;
          pend_q <= 1'b0;
        end else if (acc) begin
          if (wr) cnt_q <= cnt_q + CW'(1);
          else if (!ovf_q) ovf_q <= 1'b1;
          if (semi) pend_q <= 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (wr) mem[cnt_q[AW-1:0]] <= in_char[gi];
        rd_q <= mem[rd_addr];
      end

      assign cnt[gi]     = cnt_q;
      assign ovf[gi]     = ovf_q;
      assign pend[gi]    = pend_q;
      assign rd_data[gi] = rd_q;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last        <= 1'b1;
      gnt         <= 1'b0;
      idx         <= '0;
      chk_reset   <= 1'b1;
      resp0_valid <= 1'b0;
      resp0_ok    <= 1'b0;
      resp0_ovf   <= 1'b0;
      resp1_valid <= 1'b0;
      resp1_ok    <= 1'b0;
      resp1_ovf   <= 1'b0;
    end else begin
      chk_reset   <= 1'b0;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      case (state)
        IDLE: if (|pend) begin
          gnt  <= pick;
          last <= pick;
          // An overflowed statement is never replayed; the checker stays untouched.
          if (ovf[pick]) state <= VERD;
          else begin
            state     <= CLR;
            chk_reset <= 1'b1;
          end
        end
        CLR: begin
          idx   <= '0;
          state <= SEND;
        end
        SEND: begin
          if (CW'(idx) + CW'(1) == cnt[gnt]) state <= VERD;
          else idx <= idx + AW'(1);
        end
        VERD: begin
          if (gnt) {resp1_valid, resp1_ok, resp1_ovf} <= {1'b1, ok_now, ovf[1]};
          else     {resp0_valid, resp0_ok, resp0_ovf} <= {1'b1, ok_now, ovf[0]};
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DECL_SCHED_STATS_EN
  logic [CNT_W-1:0] ok_q, bad_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ok_q  <= '0;
      bad_q <= '0;
    end else if (state == VERD) begin
      if (ok_now) begin
        if (ok_q != '1) ok_q <= ok_q + CNT_W'(1);
      end else if (bad_q != '1) begin
        bad_q <= bad_q + CNT_W'(1);
      end
    end
  end
  assign ok_cnt  = ok_q;
  assign bad_cnt = bad_q;
`else
  assign ok_cnt  = '0;
  assign bad_cnt = '0;
`endif
endmodule

// File: tb/tb_decl_sched.sv
// Randomized bench for decl_sched with a cycle-level scheduling model and a
// behavioural declaration checker ("int <letters>;" is legal, "int int;" is not).
module tb_decl_sched;
  localparam int DEPTH = 16;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam logic [7:0] SEMI = 8'h3B;

  logic clk = 1'b0, reset = 1'b1;
  logic [1:0] v = 2'b00;
  logic [7:0] chv [2];
  logic req0_ready, req1_ready, resp0_valid, resp0_ok, resp0_ovf;
  logic resp1_valid, resp1_ok, resp1_ovf, chk_reset, chk_out_r = 1'b0;
  logic [7:0] chk_in;
  logic [CNT_W-1:0] ok_cnt, bad_cnt;

  decl_sched #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(v[0]), .req0_char(chv[0]), .req0_ready(req0_ready),
    .req1_valid(v[1]), .req1_char(chv[1]), .req1_ready(req1_ready),
    .resp0_valid(resp0_valid), .resp0_ok(resp0_ok), .resp0_ovf(resp0_ovf),
    .resp1_valid(resp1_valid), .resp1_ok(resp1_ok), .resp1_ovf(resp1_ovf),
    .chk_reset(chk_reset), .chk_in(chk_in), .chk_out(chk_out_r),
    .ok_cnt(ok_cnt), .bad_cnt(bad_cnt)
  );

  initial forever #5 clk = ~clk;

  int n_err = 0, n_chk = 0, vprob = 100;
  int cyc = -1, idle_at = 0, m_last = 1, m_ok = 0, m_bad = 0, pulses = 0;
  bit m_pend [2], m_ovf [2];
  int mlen [2], resp_at [2], semi_cyc [2], resp_cyc [2], resp_n [2];
  bit r_ok [2], r_ovf [2];
  logic [7:0] mb [2][64];
  logic [7:0] cb [64];
  int cn = 0;
  logic [7:0] exp_in [int];
  bit exp_rst [int];
  int exp_rr [int];
  bit exp_rok [int], exp_rovf [int];
  logic [7:0] dq0 [$], dq1 [$];

  function automatic void chk(input string nm, input int act, input int exp_v);
    n_chk++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", nm, cyc, act, exp_v);
    end
  endfunction

  function automatic bit legal(input logic [7:0] s [64], input int n);
    if (n < 6) return 1'b0;
    if (s[0] != 8'h69 || s[1] != 8'h6E || s[2] != 8'h74 || s[3] != 8'h20 || s[n-1] != SEMI)
      return 1'b0;
    for (int k = 4; k < n - 1; k++)
      if (s[k] < 8'h61 || s[k] > 8'h7A) return 1'b0;
    if (n == 8 && s[4] == 8'h69 && s[5] == 8'h6E && s[6] == 8'h74) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_reset();
    cyc = -1; idle_at = 0; m_last = 1; m_ok = 0; m_bad = 0;
    for (int i = 0; i < 2; i++) begin
      m_pend[i] = 0; m_ovf[i] = 0; mlen[i] = 0; resp_at[i] = -1;
    end
    exp_in.delete(); exp_rst.delete(); exp_rr.delete(); exp_rok.delete(); exp_rovf.delete();
  endfunction

  // Behavioural checker sitting on chk_reset/chk_in/chk_out.
  initial forever begin
    @(posedge clk);
    if (chk_reset) cn = 0;
    else if (chk_in != 8'h00) begin
      if (cn < 64) begin cb[cn] = chk_in; cn++; end
      if (chk_in == SEMI) chk_out_r <= legal(cb, cn);
    end
  end

  // Drivers: present the head of each queue with probability vprob.
  initial forever begin
    @(posedge clk); #1;
    if (dq0.size() > 0 && $urandom_range(0, 99) < vprob) begin v[0] = 1'b1; chv[0] = dq0[0]; end
    else begin v[0] = 1'b0; chv[0] = 8'h00; end
    if (dq1.size() > 0 && $urandom_range(0, 99) < vprob) begin v[1] = 1'b1; chv[1] = dq1[0]; end
    else begin v[1] = 1'b0; chv[1] = 8'h00; end
  end

  // Model step and compare, once per cycle on the falling edge.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      chk("rst_ready0", req0_ready, 1);  chk("rst_ready1", req1_ready, 1);
      chk("rst_resp0", resp0_valid, 0);  chk("rst_resp1", resp1_valid, 0);
      chk("rst_chk_reset", chk_reset, 1); chk("rst_chk_in", chk_in, 0);
      chk("rst_ok_cnt", ok_cnt, 0);      chk("rst_bad_cnt", bad_cnt, 0);
      model_reset();
    end else begin
      int g, r, n;
      bit ev [2];
      logic [7:0] c;
      cyc++;
      for (int i = 0; i < 2; i++)
        if (resp_at[i] == cyc) begin
          m_pend[i] = 0; m_ovf[i] = 0; mlen[i] = 0; resp_at[i] = -1;
        end
      if (exp_rr.exists(cyc)) begin
        if (exp_rok[cyc]) m_ok = (m_ok < CMAX) ? m_ok + 1 : m_ok;
        else m_bad = (m_bad < CMAX) ? m_bad + 1 : m_bad;
      end
      if (cyc >= idle_at && (m_pend[0] || m_pend[1])) begin
        g = (m_pend[0] && m_pend[1]) ? 1 - m_last : (m_pend[1] ? 1 : 0);
        m_last = g; n = mlen[g];
        if (m_ovf[g]) r = cyc + 2;
        else begin
          exp_rst[cyc+1] = 1;
          for (int k = 0; k < n; k++) exp_in[cyc+2+k] = mb[g][k];
          r = cyc + 3 + n;
        end
        resp_at[g] = r; idle_at = r; exp_rr[r] = g;
        exp_rok[r] = !m_ovf[g] && legal(mb[g], n);
        exp_rovf[r] = m_ovf[g];
      end
      chk("ready0", req0_ready, !m_pend[0]);
      chk("ready1", req1_ready, !m_pend[1]);
      chk("chk_reset", chk_reset, (cyc == 0 || exp_rst.exists(cyc)) ? 1 : 0);
      chk("chk_in", chk_in, exp_in.exists(cyc) ? exp_in[cyc] : 8'h00);
      for (int i = 0; i < 2; i++) ev[i] = exp_rr.exists(cyc) && exp_rr[cyc] == i;
      chk("resp0_valid", resp0_valid, ev[0]);
      chk("resp1_valid", resp1_valid, ev[1]);
      if (ev[0]) begin chk("resp0_ok", resp0_ok, exp_rok[cyc]); chk("resp0_ovf", resp0_ovf, exp_rovf[cyc]); end
      if (ev[1]) begin chk("resp1_ok", resp1_ok, exp_rok[cyc]); chk("resp1_ovf", resp1_ovf, exp_rovf[cyc]); end
`ifdef DECL_SCHED_STATS_EN
      chk("ok_cnt", ok_cnt, m_ok);  chk("bad_cnt", bad_cnt, m_bad);
`else
      chk("ok_cnt", ok_cnt, 0);     chk("bad_cnt", bad_cnt, 0);
`endif
      if (resp0_valid) begin resp_cyc[0] = cyc; r_ok[0] = resp0_ok; r_ovf[0] = resp0_ovf; resp_n[0]++; end
      if (resp1_valid) begin resp_cyc[1] = cyc; r_ok[1] = resp1_ok; r_ovf[1] = resp1_ovf; resp_n[1]++; end
      if (chk_reset && cyc > 0) pulses++;
      for (int i = 0; i < 2; i++)
        if (v[i] && !m_pend[i]) begin
          c = chv[i];
          if (m_ovf[i]) begin
            if (c == SEMI) m_pend[i] = 1;
          end else if (c == SEMI || mlen[i] < DEPTH - 1) begin
            mb[i][mlen[i]] = c; mlen[i]++;
            if (c == SEMI) m_pend[i] = 1;
          end else m_ovf[i] = 1;
          if (c == SEMI) semi_cyc[i] = cyc;
          if (i == 0) void'(dq0.pop_front()); else void'(dq1.pop_front());
        end
    end
  end

  task automatic push_c(input int i, input logic [7:0] c);
    if (i == 0) dq0.push_back(c); else dq1.push_back(c);
  endtask

  task automatic push_str(input int i, input string s);
    for (int k = 0; k < s.len(); k++) push_c(i, s[k]);
  endtask

  task automatic letters(input int i, input int n);
    for (int k = 0; k < n; k++) push_c(i, 8'($urandom_range(97, 122)));
  endtask

  task automatic push_rand(input int i);
    case ($urandom_range(0, 4))
      0: begin push_str(i, "int "); letters(i, $urandom_range(1, 4)); push_c(i, SEMI); end
      1: push_str(i, "int int;");
      2: push_c(i, SEMI);
      3: begin letters(i, $urandom_range(0, 22)); push_c(i, SEMI); end
      default: begin push_str(i, "int "); letters(i, $urandom_range(8, 14)); push_c(i, SEMI); end
    endcase
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    bit busy;
    do begin
      @(negedge clk); #1; k++;
      busy = dq0.size() > 0 || dq1.size() > 0 || m_pend[0] || m_pend[1] || cyc < idle_at;
    end while (busy && k < budget);
    chk("timeout", busy ? 1 : 0, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #3 reset = 1'b1;
    dq0.delete(); dq1.delete(); v = 2'b00;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
  endtask

  initial begin
    int p0, n0;
    chv[0] = 8'h00; chv[1] = 8'h00;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    p0 = pulses; push_str(0, "int a;"); wait_done(200);
    chk("t1_latency", resp_cyc[0] - semi_cyc[0], 10);
    chk("t1_ok", r_ok[0], 1); chk("t1_ovf", r_ovf[0], 0); chk("t1_pulses", pulses - p0, 1);

    push_str(1, "int int;"); wait_done(200);
    chk("t2_latency", resp_cyc[1] - semi_cyc[1], 12);
    chk("t2_ok", r_ok[1], 0); chk("t2_ovf", r_ovf[1], 0);

    do_reset();
    push_str(0, "int a;"); push_str(1, "int b;"); wait_done(300);
    chk("t3_same_edge", semi_cyc[1] - semi_cyc[0], 0);
    chk("t3_order", resp_cyc[1] - resp_cyc[0], 9);
    chk("t3_ok0", r_ok[0], 1); chk("t3_ok1", r_ok[1], 1);

    p0 = pulses;
    for (int k = 0; k < 20; k++) push_c(0, 8'h61);
    push_c(0, SEMI); wait_done(300);
    chk("t4_latency", resp_cyc[0] - semi_cyc[0], 3);
    chk("t4_ok", r_ok[0], 0); chk("t4_ovf", r_ovf[0], 1); chk("t4_pulses", pulses - p0, 0);

    n0 = resp_n[0]; push_str(0, "int abc;");
    for (int k = 0; k < 40 && !exp_in.exists(cyc); k++) @(negedge clk);
    chk("t5_send_seen", chk_in, 8'h69);
    @(posedge clk); #3 reset = 1'b1; #1;
    chk("t5_rst_ready0", req0_ready, 1); chk("t5_rst_chk_reset", chk_reset, 1);
    chk("t5_rst_chk_in", chk_in, 0);
    dq0.delete(); dq1.delete(); v = 2'b00;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("t5_no_resp", resp_n[0] - n0, 0);
    push_str(0, "int b;"); wait_done(200);
    chk("t5_ok", r_ok[0], 1); chk("t5_one_resp", resp_n[0] - n0, 1);

    do_reset();
    push_str(0, "int a;"); push_str(0, "int bc;"); push_str(0, "int int;"); push_str(0, "int xyz;");
    wait_done(400);
`ifdef DECL_SCHED_STATS_EN
    chk("t6_ok_cnt", ok_cnt, 3); chk("t6_bad_cnt", bad_cnt, 1);
`else
    chk("t6_ok_cnt", ok_cnt, 0); chk("t6_bad_cnt", bad_cnt, 0);
`endif
    for (int k = 0; k < 260; k++) push_c(1, SEMI);
    wait_done(5000);
`ifdef DECL_SCHED_STATS_EN
    chk("t6_bad_sat", bad_cnt, 255);
`else
    chk("t6_bad_sat", bad_cnt, 0);
`endif

    vprob = 60;
    for (int it = 0; it < 15; it++) begin
      push_rand(0); push_rand(1); push_rand(0); push_rand(1);
      wait_done(3000);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/decl_sched.md
# decl_sched

Two-port statement scheduler in front of the shared declaration syntax checker. Each requester streams characters into its own statement buffer. When a requester's buffer holds a complete `;`-terminated statement, the block grants the checker to it round-robin, clears the checker, replays the statement contiguously, and returns the pass/fail verdict to that requester.

## Interface

**Parameters**
- `DEPTH`, default 16: statement buffer entries per requester, `;` included; power of two.
- `CNT_W`, default 8: width of the statistics counters.

**Ports**
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `req0_valid` / `req1_valid` in 1: a character is offered.
- `req0_char` / `req1_char` in 8: ASCII character.
- `req0_ready` / `req1_ready` out 1: the character is accepted on any edge where valid && ready.
- `resp0_valid` / `resp1_valid` out 1: one-cycle verdict pulse.
- `resp0_ok` / `resp1_ok` out 1: statement is legal; valid only with resp_valid.
- `resp0_ovf` / `resp1_ovf` out 1: statement exceeded the buffer; valid only with resp_valid.
- `chk_reset` out 1: synchronous reset to the checker; registered.
- `chk_in` out 8: character to the checker.
- `chk_out` in 1: checker verdict, registered inside the checker.
- `ok_cnt`, `bad_cnt` out CNT_W: statistics counters (see Configuration).

## Operation

**Per-requester buffer**
- Holds a count, an overflow flag and a pending flag.
- `reqN_ready` = !pendingN.
- Accept with count < DEPTH-1, or with char == `;` and count ≤ DEPTH-1: store the character and increment count. If the char is `;`, set pendingN.
- Accept a non-`;` char with count == DEPTH-1: set ovfN; do not store it.
- While ovfN is set: discard every character. Accepting `;` sets pendingN.

**Arbiter**
- Round-robin pointer `last`; reset value 1, so requester 0 wins first.
- If both requesters are pending in IDLE, grant the one != last.
- On grant, `last` takes the granted index.

**FSM**
- IDLE: if any requester is pending, grant it. Go to VERD if the granted ovf flag is set, else go to CLR.
- CLR: drive `chk_reset`=1 for exactly this cycle, then go to SEND with index 0.
- SEND: drive `chk_in` = buf[idx], one character per cycle with no gaps. After the cycle that drives `;`, go to VERD.
- VERD: sample `chk_out`, or force ok=0 if ovf is set. At the closing edge:
  - register respN_valid=1, respN_ok, respN_ovf;
  - clear pendingN, countN, ovfN;
  - go to IDLE.

**Outputs**
- `chk_in` = 8'h00 outside SEND.
- resp_valid is high for exactly one cycle, in the cycle after VERD.
- The non-granted requester keeps filling its buffer throughout.

## Timing

**Reset values**
- All resp outputs 0; `chk_in`=0; counters 0.
- `req*_ready`=1.
- `chk_reset`=1, held through reset and the first cycle after release, so the checker is reset on that edge; then 0.
- FSM = IDLE.

**Latency**
- The `;` of an n-character statement is accepted at the end of cycle A, with the FSM idle.
- Grant in A+1, CLR in A+2, SEND in A+3..A+2+n, VERD in A+3+n.
- resp_valid in A+4+n.
- Overflow path: VERD in A+2, resp_valid in A+3; the checker is untouched.
- Verdict sampling: `chk_out` updates on the edge that consumes `;` and is sampled during VERD.

**Boundary conditions**
- Requester re-arm: readyN returns 1 in the same cycle as respN_valid. A new character is accepted on that cycle's edge.
- Simultaneous completion: both pendings set on the same edge. Requester != last is served first; the other is granted in the IDLE following its VERD.
- Empty statement `;`: n=1, checked normally.
- Reset asserted mid-SEND or mid-VERD: immediate return to reset values; no resp is issued; buffered statements are lost.

## Configuration

- `DECL_SCHED_STATS_EN` defined:
  - `ok_cnt` increments on each resp with ok=1.
  - `bad_cnt` increments on each resp with ok=0, overflow included.
  - Both saturate at 2^CNT_W-1.
- Undefined: the counters are not built and `ok_cnt`/`bad_cnt` are tied to 0.

## Test plan

- After reset, req0 streams `int a;` (6 chars) back-to-back:
  - `chk_reset` pulses once;
  - `chk_in` carries `int a;` in consecutive cycles;
  - resp0_valid=1, resp0_ok=1, resp0_ovf=0 in A+10.
- req1 sends `int int;` -> resp1_ok=0, resp1_ovf=0; req1_ready is 0 from A+1 until the resp cycle.
- Both requesters' `;` accepted on the same edge right after reset -> req0 served first; req1's CLR follows req0's resp cycle; both verdicts correct.
- req0 sends 20×`a` then `;` -> resp0_valid in A+3 with ok=0, ovf=1; `chk_reset` never pulses; `chk_in` stays 0.
- Assert reset during SEND of `int abc;` -> outputs return to reset values within the cycle; no resp; a following `int b;` gets ok=1.
- With `DECL_SCHED_STATS_EN`: 3 legal statements and 1 illegal -> ok_cnt=3, bad_cnt=1; 260 illegal statements -> bad_cnt holds at 255.
